control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle sequencer for the processor datapath. Holds the program counter and instruction register, fetches 16-bit instructions from a synchronous instruction ROM, decodes them, and drives every datapath control line (data memory address/write, register-file ports, write-back mux select, ALU select) one state at a time. Sits between the instruction memory and the datapath in the top-level processor.

## Interface
- PC_W, 7, program counter / instruction address width
- clk  in  1  rising-edge clock shared with the datapath
- reset  in  1  synchronous, active-high
- resume  in  1  single-cycle pulse releasing HALT (used only with CTRL_HALT_RESUME_EN)
- instr_addr  out  PC_W  instruction ROM address (= PC register)
- instr_data  in  16  instruction ROM registered output, valid one cycle after address is sampled
- D_Addr  out  8  data memory address
- D_wr  out  1  data memory write enable
- RF_s  out  1  write-back mux select: 0 = ALU, 1 = data memory
- RF_W_addr  out  4  register-file write address
- RF_W_en  out  1  register-file write enable
- RF_Ra_addr  out  4  register-file read port A
- RF_Rb_addr  out  4  register-file read port B
- Alu_s0  out  3  ALU op: 000 pass-zero, 001 A+B, 010 A−B
- state_out  out  4  current state encoding, for debug display
- halted  out  1  high while in HALT

## Operation
- Instruction format: [15:12] opcode; ADD/SUB: [11:8] Ra, [7:4] Rb, [3:0] Rd; LOAD/STORE: [11:4] data address, [3:0] register.
- Opcodes: 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB, 0101 HALT; 0110–1111 decode as NOOP.
- States (state_out): INIT 0, FETCH 1, DECODE 2, LOAD_A 3, LOAD_B 4, STORE 5, ADD 6, SUB 7, HALT 8.
- INIT: PC <= 0; -> FETCH.
- FETCH: instr_addr = PC; ROM samples PC at the closing edge; PC <= PC+1 at that edge; -> DECODE.
- DECODE: IR <= instr_data at closing edge; next state chosen from instr_data[15:12]; NOOP -> FETCH.
- STORE: D_Addr = IR[11:4], RF_Ra_addr = IR[3:0], D_wr = 1; -> FETCH.
- LOAD_A: D_Addr = IR[11:4], RF_s = 1; -> LOAD_B. LOAD_B: D_Addr held, RF_s = 1, RF_W_addr = IR[3:0], RF_W_en = 1; -> FETCH.
- ADD/SUB: RF_Ra_addr = IR[11:8], RF_Rb_addr = IR[7:4], RF_W_addr = IR[3:0], Alu_s0 = 001/010, RF_s = 0, RF_W_en = 1; -> FETCH.
- HALT: all enables low, halted = 1; PC frozen.
- Control outputs are Moore functions of state and IR; in any state not listed as driving a signal, it is 0.
- PC wraps 2^PC_W−1 -> 0 without flag.

## Timing
- Reset: on any edge with reset = 1, state <= INIT, PC <= 0, IR <= 0; all outputs 0 in the following cycle (state_out = 0, halted = 0). Reset mid-LOAD or mid-STORE aborts: no RF_W_en / D_wr pulse after the reset edge.
- Cycles per instruction: NOOP/invalid 2, STORE 3, ADD/SUB 3, LOAD 4; first FETCH occurs the cycle after INIT.
- D_wr and RF_W_en are each asserted for exactly one cycle per instruction; never both in the same cycle.
- resume and reset in the same cycle: reset wins.
- PC increment occurs only on FETCH exit; a HALT leaves PC pointing to the word after HALT.

## Configuration
- CTRL_HALT_RESUME_EN defined: in HALT, resume = 1 -> FETCH next cycle, continuing at PC (instruction after HALT).
- Undefined: HALT is terminal until reset; resume is ignored.

## Test plan
- Reset held 2 cycles mid-ADD, released -> state_out 0 then 1, instr_addr 0, RF_W_en never high after reset edge.
- ROM[0] = 16'h2153 (LOAD R3 <- D[0x15]) -> states 1,2,3,4; D_Addr = 0x15 in states 3–4, RF_s = 1, RF_W_en high only in state 4 with RF_W_addr = 3.
- ROM[1] = 16'h3124 (ADD R4 = R1+R2) -> state 6 for one cycle: Ra 1, Rb 2, W 4, Alu_s0 001, RF_W_en 1, RF_s 0.
- ROM[2] = 16'h1A07 (STORE D[0xA0] <- R7) -> state 5: D_Addr 0xA0, RF_Ra_addr 7, D_wr 1 one cycle, RF_W_en 0.
- ROM[3] = 16'hF000 then 16'h5000 -> invalid treated as NOOP (2 cycles), then HALT: halted 1, instr_addr 5 held for 20 cycles.
- With CTRL_HALT_RESUME_EN: resume pulse in HALT -> FETCH next cycle at instr_addr 5; without macro, state stays 8.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving the datapath control lines.
// Optional feature: define CTRL_HALT_RESUME_EN to let a resume pulse leave HALT.
module control_unit #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            resume,
  output logic [PC_W-1:0] instr_addr,
  input  logic [15:0]     instr_data,
  output logic [7:0]      D_Addr,
  output logic            D_wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_addr,
  output logic            RF_W_en,
  output logic [3:0]      RF_Ra_addr,
  output logic [3:0]      RF_Rb_addr,
  output logic [2:0]      Alu_s0,
  output logic [3:0]      state_out,
  output logic            halted
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD_A = 4'd3,
    S_LOAD_B = 4'd4,
    S_STORE  = 4'd5,
    S_ADD    = 4'd6,
    S_SUB    = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  // Only the operand field is kept; the opcode is consumed straight from the ROM in DECODE.
  logic [11:0]     ir_q, ir_d;

  logic [7:0] d_addr_q, d_addr_d;
  logic       d_wr_q, d_wr_d;
  logic       rf_s_q, rf_s_d;
  logic [3:0] rf_w_addr_q, rf_w_addr_d;
  logic       rf_w_en_q, rf_w_en_d;
  logic [3:0] rf_ra_addr_q, rf_ra_addr_d;
  logic [3:0] rf_rb_addr_q, rf_rb_addr_d;
  logic [2:0] alu_s0_q, alu_s0_d;
  logic       halted_q, halted_d;

`ifdef CTRL_HALT_RESUME_EN
  logic resume_go;
  assign resume_go = resume;
`else
  logic resume_go;
  logic unused_resume;
  assign resume_go     = 1'b0;
  assign unused_resume = resume;
`endif

  // Next-state, PC and IR update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_INIT: begin
        pc_d    = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d = instr_data[11:0];
        case (instr_data[15:12])
          4'h1:    state_d = S_STORE;
          4'h2:    state_d = S_LOAD_A;
          4'h3:    state_d = S_ADD;
          4'h4:    state_d = S_SUB;
          4'h5:    state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B, S_STORE, S_ADD, S_SUB: state_d = S_FETCH;
      S_HALT: begin
        if (resume_go) state_d = S_FETCH;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Outputs are decoded from the upcoming state/IR so the registered copies
  // line up exactly with the state they belong to.
  always_comb begin
    d_addr_d     = '0;
    d_wr_d       = 1'b0;
    rf_s_d       = 1'b0;
    rf_w_addr_d  = '0;
    rf_w_en_d    = 1'b0;
    rf_ra_addr_d = '0;
    rf_rb_addr_d = '0;
    alu_s0_d     = 3'b000;
    halted_d     = 1'b0;
    case (state_d)
      S_STORE: begin
        d_addr_d     = ir_d[11:4];
        rf_ra_addr_d = ir_d[3:0];
        d_wr_d       = 1'b1;
      end
      S_LOAD_A: begin
        d_addr_d = ir_d[11:4];
        rf_s_d   = 1'b1;
      end
      S_LOAD_B: begin
        d_addr_d    = ir_d[11:4];
        rf_s_d      = 1'b1;
        rf_w_addr_d = ir_d[3:0];
        rf_w_en_d   = 1'b1;
      end
      S_ADD, S_SUB: begin
        rf_ra_addr_d = ir_d[11:8];
        rf_rb_addr_d = ir_d[7:4];
        rf_w_addr_d  = ir_d[3:0];
        rf_w_en_d    = 1'b1;
        alu_s0_d     = (state_d == S_ADD) ? 3'b001 : 3'b010;
      end
      S_HALT: halted_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_INIT;
      pc_q         <= '0;
      ir_q         <= '0;
      d_addr_q     <= '0;
      d_wr_q       <= 1'b0;
      rf_s_q       <= 1'b0;
      rf_w_addr_q  <= '0;
      rf_w_en_q    <= 1'b0;
      rf_ra_addr_q <= '0;
      rf_rb_addr_q <= '0;
      alu_s0_q     <= 3'b000;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      d_addr_q     <= d_addr_d;
      d_wr_q       <= d_wr_d;
      rf_s_q       <= rf_s_d;
      rf_w_addr_q  <= rf_w_addr_d;
      rf_w_en_q    <= rf_w_en_d;
      rf_ra_addr_q <= rf_ra_addr_d;
      rf_rb_addr_q <= rf_rb_addr_d;
      alu_s0_q     <= alu_s0_d;
      halted_q     <= halted_d;
    end
  end

  assign instr_addr = pc_q;
  assign D_Addr     = d_addr_q;
  assign D_wr       = d_wr_q;
  assign RF_s       = rf_s_q;
  assign RF_W_addr  = rf_w_addr_q;
  assign RF_W_en    = rf_w_en_q;
  assign RF_Ra_addr = rf_ra_addr_q;
  assign RF_Rb_addr = rf_rb_addr_q;
  assign Alu_s0     = alu_s0_q;
  assign state_out  = state_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction-level trace model compared every cycle,
// plus directed literal checks of the reference program.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        resume;
  logic [6:0]  instr_addr;
  logic [15:0] instr_data;
  logic [7:0]  D_Addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  Alu_s0;
  logic [3:0]  state_out;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  control_unit #(.PC_W(7)) dut (
    .clk(clk), .reset(reset), .resume(resume),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .D_Addr(D_Addr), .D_wr(D_wr), .RF_s(RF_s),
    .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
    .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
    .Alu_s0(Alu_s0), .state_out(state_out), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction ROM.
  logic [15:0] rom [128];
  always @(posedge clk) instr_data <= rom[instr_addr];

  typedef struct packed {
    logic [3:0] st;
    logic [6:0] addr;
    logic [7:0] daddr;
    logic       dwr;
    logic       rfs;
    logic [3:0] wa;
    logic       wen;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
    logic       h;
  } rec_t;

  // Model: each instruction expands into a list of per-cycle expected outputs.
  rec_t       q[$];
  rec_t       exp_r;
  logic [6:0] m_pc;
  bit         m_halted;
  bit         chk_en = 0;

  function automatic rec_t base(input logic [3:0] st, input logic [6:0] a);
    rec_t r;
    r = '0;
    r.st = st;
    r.addr = a;
    return r;
  endfunction

  task automatic gen();
    logic [15:0] w;
    logic [6:0]  a, n;
    rec_t        r;
    w = rom[m_pc];
    a = m_pc;
    n = a + 7'd1;
    q.push_back(base(4'd1, a));
    q.push_back(base(4'd2, n));
    r = base(4'd0, n);
    case (w[15:12])
      4'h1: begin
        r.st = 4'd5; r.daddr = w[11:4]; r.dwr = 1'b1; r.ra = w[3:0];
        q.push_back(r);
      end
      4'h2: begin
        r.st = 4'd3; r.daddr = w[11:4]; r.rfs = 1'b1;
        q.push_back(r);
        r.st = 4'd4; r.wa = w[3:0]; r.wen = 1'b1;
        q.push_back(r);
      end
      4'h3, 4'h4: begin
        r.st  = (w[15:12] == 4'h3) ? 4'd6 : 4'd7;
        r.alu = (w[15:12] == 4'h3) ? 3'd1 : 3'd2;
        r.ra = w[11:8]; r.rb = w[7:4]; r.wa = w[3:0]; r.wen = 1'b1;
        q.push_back(r);
      end
      4'h5: begin
        r.st = 4'd8; r.h = 1'b1;
        q.push_back(r);
        m_halted = 1;
      end
      default: ;
    endcase
    m_pc = n;
  endtask

  task automatic model_step();
    rec_t r;
    if (reset) begin
      q.delete();
      m_pc = 7'd0;
      m_halted = 0;
      exp_r = base(4'd0, 7'd0);
    end else begin
      if (q.size() == 0) begin
        if (m_halted) begin
`ifdef CTRL_HALT_RESUME_EN
          if (resume) begin
            m_halted = 0;
            gen();
          end
`endif
        end else begin
          gen();
        end
      end
      if (q.size() != 0) begin
        exp_r = q.pop_front();
      end else begin
        r = base(4'd8, m_pc);
        r.h = 1'b1;
        exp_r = r;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      chk_en = 1;
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    rec_t act;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        act = {state_out, instr_addr, D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, Alu_s0, halted};
        n_tests++;
        if (act !== exp_r) begin
          n_fail++;
          $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, act, exp_r);
        end
        if (D_wr === 1'b1 && RF_W_en === 1'b1) begin
          n_tests++;
          n_fail++;
          $display("FAIL dwr_wen_overlap t=%0t actual=11 required=not both", $time);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  int exp_st[16] = '{0, 1, 2, 3, 4, 1, 2, 6, 1, 2, 5, 1, 2, 1, 2, 8};

  initial begin
    logic [31:0] rnd;
    logic [3:0]  op;
    reset  = 1'b1;
    resume = 1'b0;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0] = 16'h2153;
    rom[1] = 16'h3124;
    rom[2] = 16'h1A07;
    rom[3] = 16'hF000;
    rom[4] = 16'h5000;

    // Directed reference program.
    repeat (2) @(negedge clk);
    check("rst_state", {28'd0, state_out}, 32'd0);
    check("rst_addr", {25'd0, instr_addr}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_en", {30'd0, D_wr, RF_W_en}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("seq_state_%0d", i), {28'd0, state_out}, exp_st[i]);
      if (i == 3) begin
        check("loada_daddr", {24'd0, D_Addr}, 32'h15);
        check("loada_rfs", {31'd0, RF_s}, 32'd1);
        check("loada_wen", {31'd0, RF_W_en}, 32'd0);
      end
      if (i == 4) begin
        check("loadb_daddr", {24'd0, D_Addr}, 32'h15);
        check("loadb_wen", {31'd0, RF_W_en}, 32'd1);
        check("loadb_waddr", {28'd0, RF_W_addr}, 32'd3);
      end
      if (i == 7) begin
        check("add_ports", {20'd0, RF_Ra_addr, RF_Rb_addr, RF_W_addr}, 32'h124);
        check("add_alu", {29'd0, Alu_s0}, 32'd1);
        check("add_en", {30'd0, RF_W_en, RF_s}, 32'b10);
      end
      if (i == 10) begin
        check("store_daddr", {24'd0, D_Addr}, 32'hA0);
        check("store_ra", {28'd0, RF_Ra_addr}, 32'd7);
        check("store_en", {30'd0, D_wr, RF_W_en}, 32'b10);
      end
      if (i == 11) check("store_dwr_once", {31'd0, D_wr}, 32'd0);
    end
    check("halt_flag", {31'd0, halted}, 32'd1);
    repeat (20) begin
      @(negedge clk);
      check("halt_hold", {21'd0, state_out, instr_addr}, {21'd0, 4'd8, 7'd5});
    end

    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
`ifdef CTRL_HALT_RESUME_EN
    check("resume", {21'd0, state_out, instr_addr}, {21'd0, 4'd1, 7'd5});
`else
    check("resume_ignored", {21'd0, state_out, instr_addr}, {21'd0, 4'd8, 7'd5});
`endif

    // Reset held two cycles in the middle of an ADD.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (7) @(negedge clk);
    check("midadd_state", {28'd0, state_out}, 32'd6);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("midadd_rst", {27'd0, state_out, RF_W_en}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("midadd_fetch", {21'd0, state_out, instr_addr}, {21'd0, 4'd1, 7'd0});

    // Randomized programs, resume pulses and occasional resets.
    for (int ep = 0; ep < 40; ep++) begin
      @(negedge clk);
      reset  = 1'b1;
      resume = 1'b0;
      for (int i = 0; i < 128; i++) begin
        rnd = $urandom();
        op  = rnd[15:12];
        if (op == 4'h5 && rnd[20:18] != 3'd0) op = 4'h3;
        rom[i] = {op, rnd[11:0]};
      end
      repeat ($urandom_range(1, 2)) @(negedge clk);
      reset = 1'b0;
      repeat ($urandom_range(50, 150)) begin
        @(negedge clk);
        resume = ($urandom_range(0, 7) == 0);
        reset  = ($urandom_range(0, 99) == 0);
      end
      reset  = 1'b0;
      resume = 1'b0;
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t actual=running required=finished", $time);
    $fatal(1, "timeout");
  end

endmodule
